// File: rtl/counter_sequencer_if.sv
// Counter-side bus: the sequencer (master) issues step/load commands and
// reads back the current count from the up/down counter (slave).
interface counter_sequencer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] count;
    logic             cnt_en;
    logic             cnt_dir;
    logic             cnt_load;
    logic [WIDTH-1:0] load_val;

    modport master (
        input  count,
        output cnt_en,
        output cnt_dir,
        output cnt_load,
        output load_val
    );

    modport slave (
        output count,
        input  cnt_en,
        input  cnt_dir,
        input  cnt_load,
        input  load_val
    );
endinterface

// File: rtl/counter_sequencer.sv
// Control FSM turning board buttons/switches and the divider tick into counter
// step/load commands. Define BOUNCE_MODE_EN to reverse at limits when bounce_sw=1.
module counter_sequencer #(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_tick,
    input  logic                 i_start_btn,
    input  logic                 i_stop_btn,
    input  logic                 i_dir_sw,
    input  logic                 i_bounce_sw,
    output logic [1:0]           o_state_led,
    counter_sequencer_if.master  io_cnt
);
    localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_start_sync;
    logic [1:0]       r_stop_sync;
    logic             r_start_prev;
    logic             r_stop_prev;
    logic             w_start_ev;
    logic             w_stop_ev;
    logic             r_dir_q;
    logic             w_dir_nxt;
    logic             r_cnt_en;
    logic             w_cnt_en_nxt;
    logic             r_cnt_load;
    logic             w_cnt_load_nxt;
    logic [WIDTH-1:0] r_load_val;
    logic [WIDTH-1:0] w_load_val_nxt;
    logic [WIDTH-1:0] w_reload_val;
    logic             w_lim;
    logic             w_step_ok;

`ifndef BOUNCE_MODE_EN
    logic             w_unused_bounce;
    assign w_unused_bounce = i_bounce_sw;
`endif

    // Two-flop synchronizers, then a registered previous value for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_sync <= '0;
            r_stop_sync  <= '0;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
        end else begin
            r_start_sync <= {r_start_sync[0], i_start_btn};
            r_stop_sync  <= {r_stop_sync[0], i_stop_btn};
            r_start_prev <= r_start_sync[1];
            r_stop_prev  <= r_stop_sync[1];
        end
    end

    assign w_start_ev   = r_start_sync[1] & ~r_start_prev;
    assign w_stop_ev    = r_stop_sync[1] & ~r_stop_prev;
    assign w_lim        = r_dir_q ? (io_cnt.count == L_MAX) : (io_cnt.count == L_MIN);
    assign w_reload_val = i_dir_sw ? L_MIN : L_MAX;
    // A tick held high would otherwise issue back-to-back steps.
    assign w_step_ok    = i_tick & ~r_cnt_en;

    always_comb begin
        w_state_nxt    = r_state;
        w_dir_nxt      = r_dir_q;
        w_cnt_en_nxt   = 1'b0;
        w_cnt_load_nxt = 1'b0;
        w_load_val_nxt = r_load_val;
        case (r_state)
            IDLE: begin
                if (w_start_ev && !w_stop_ev) begin
                    w_cnt_load_nxt = 1'b1;
                    w_load_val_nxt = w_reload_val;
                    w_dir_nxt      = i_dir_sw;
                    w_state_nxt    = RUN;
                end
            end
            RUN: begin
                if (w_stop_ev) begin
                    w_state_nxt = PAUSE;
                end else if (w_step_ok) begin
                    if (!w_lim) begin
                        w_cnt_en_nxt = 1'b1;
                    end else begin
`ifdef BOUNCE_MODE_EN
                        if (i_bounce_sw) begin
                            w_dir_nxt    = ~r_dir_q;
                            w_cnt_en_nxt = 1'b1;
                        end else begin
                            w_state_nxt = DONE;
                        end
`else
                        w_state_nxt = DONE;
`endif
                    end
                end
            end
            PAUSE: begin
                if (w_stop_ev) begin
                    w_state_nxt = IDLE;
                end else if (w_start_ev) begin
                    w_state_nxt = RUN;
                end
            end
            DONE: begin
                if (w_stop_ev) begin
                    w_state_nxt = IDLE;
                end else if (w_start_ev) begin
                    w_cnt_load_nxt = 1'b1;
                    w_load_val_nxt = w_reload_val;
                    w_dir_nxt      = i_dir_sw;
                    w_state_nxt    = RUN;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dir_q    <= 1'b1;
            r_cnt_en   <= 1'b0;
            r_cnt_load <= 1'b0;
            r_load_val <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_dir_q    <= w_dir_nxt;
            r_cnt_en   <= w_cnt_en_nxt;
            r_cnt_load <= w_cnt_load_nxt;
            r_load_val <= w_load_val_nxt;
        end
    end

    assign io_cnt.cnt_en   = r_cnt_en;
    assign io_cnt.cnt_dir  = r_dir_q;
    assign io_cnt.cnt_load = r_cnt_load;
    assign io_cnt.load_val = r_load_val;
    assign o_state_led     = r_state;
endmodule

// File: tb/tb_counter_sequencer.sv
// Randomized + directed bench for counter_sequencer against an event-level model;
// the bench also plays the role of the counter feeding count back.
module tb_counter_sequencer;
    localparam int WIDTH   = 4;
    localparam int MINV    = 0;
    localparam int MAXV    = 15;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;
`ifdef BOUNCE_MODE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             start_btn = 1'b0;
    logic             stop_btn  = 1'b0;
    logic             dir_sw    = 1'b1;
    logic             bounce_sw = 1'b0;
    logic             auto_tick = 1'b0;
    logic             man_tick  = 1'b0;
    logic             tick_auto = 1'b0;
    logic             tick;
    logic [1:0]       state_led;
    logic [WIDTH-1:0] cnt_val   = '0;

    assign tick = auto_tick | man_tick;

    counter_sequencer_if #(.WIDTH(WIDTH)) bus ();
    assign bus.count = cnt_val;

    counter_sequencer #(.WIDTH(WIDTH), .MIN_VAL(MINV), .MAX_VAL(MAXV)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_tick      (tick),
        .i_start_btn (start_btn),
        .i_stop_btn  (stop_btn),
        .i_dir_sw    (dir_sw),
        .i_bounce_sw (bounce_sw),
        .o_state_led (state_led),
        .io_cnt      (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    bit         chk_on = 1'b0;
    int         m_state = S_IDLE;
    bit         m_dir  = 1'b1;
    bit         m_en   = 1'b0;
    bit         m_load = 1'b0;
    logic [3:0] m_lval = 4'd0;
    bit   [2:0] s_hist = 3'b0;
    bit   [2:0] p_hist = 3'b0;
    int         ovr_seq  = 0;
    int         ovr_seen = 0;
    logic [3:0] ovr_val  = 4'd0;
    int         tcnt     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock edge of the reference: a button press is seen as an event two
    // samples after its rising edge; stop outranks start and tick.
    task automatic model_step();
        bit s_ev, p_ev, lim;
        if (ovr_seq != ovr_seen) begin
            cnt_val  <= ovr_val;
            ovr_seen = ovr_seq;
        end else if (m_load) begin
            cnt_val <= m_lval;
        end else if (m_en) begin
            cnt_val <= m_dir ? cnt_val + 4'd1 : cnt_val - 4'd1;
        end
        s_ev   = s_hist[1] & ~s_hist[2];
        p_ev   = p_hist[1] & ~p_hist[2];
        s_hist = {s_hist[1:0], start_btn};
        p_hist = {p_hist[1:0], stop_btn};
        lim    = m_dir ? (cnt_val == 4'(MAXV)) : (cnt_val == 4'(MINV));
        m_en   = 1'b0;
        m_load = 1'b0;
        if (rst) begin
            m_state = S_IDLE;
            m_dir   = 1'b1;
            m_lval  = 4'd0;
            s_hist  = 3'b0;
            p_hist  = 3'b0;
        end else begin
            if ((m_state == S_IDLE || m_state == S_DONE) && s_ev && !p_ev) begin
                m_load  = 1'b1;
                m_lval  = dir_sw ? 4'(MINV) : 4'(MAXV);
                m_dir   = dir_sw;
                m_state = S_RUN;
            end else if ((m_state == S_PAUSE || m_state == S_DONE) && p_ev) begin
                m_state = S_IDLE;
            end else if (m_state == S_PAUSE && s_ev) begin
                m_state = S_RUN;
            end else if (m_state == S_RUN && p_ev) begin
                m_state = S_PAUSE;
            end else if (m_state == S_RUN && tick) begin
                if (!lim) begin
                    m_en = 1'b1;
                end else if (BOUNCE && bounce_sw) begin
                    m_dir = !m_dir;
                    m_en  = 1'b1;
                end else begin
                    m_state = S_DONE;
                end
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic observe(input int n, output int ens, output int lds);
        ens = 0;
        lds = 0;
        repeat (n) begin
            @(negedge clk);
            ens += int'(bus.cnt_en);
            lds += int'(bus.cnt_load);
        end
    endtask

    task automatic press(input bit is_stop, output int lds);
        lds = 0;
        @(negedge clk);
        if (is_stop) stop_btn = 1'b1;
        else start_btn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            lds += int'(bus.cnt_load);
        end
        if (is_stop) stop_btn = 1'b0;
        else start_btn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            lds += int'(bus.cnt_load);
        end
    endtask

    task automatic wait_en();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.cnt_en) seen = 1'b1;
        end
        check("step_seen", 32'(seen), 32'd1);
    endtask

    task automatic force_count(input logic [3:0] v);
        ovr_val = v;
        ovr_seq++;
    endtask

    initial begin
        int  ens, lds;
        bit  found, en_at;
        fork
            forever begin
                @(posedge clk);
                model_step();
            end
            forever begin
                @(negedge clk);
                if (tick_auto) begin
                    auto_tick = (tcnt == 0);
                    tcnt      = (tcnt == 9) ? 0 : tcnt + 1;
                end else begin
                    auto_tick = 1'b0;
                end
            end
            forever begin
                @(negedge clk);
                if (chk_on) begin
                    total++;
                    if ({bus.cnt_en, bus.cnt_load, bus.cnt_dir, bus.load_val, state_led} !==
                        {m_en, m_load, m_dir, m_lval, 2'(m_state)}) begin
                        bad++;
                        if (bad < 30)
                            $display("FAIL cycle_compare @%0t: dut en=%b ld=%b dir=%b lv=%0d st=%0d, model en=%b ld=%b dir=%b lv=%0d st=%0d",
                                     $time, bus.cnt_en, bus.cnt_load, bus.cnt_dir, bus.load_val, state_led,
                                     m_en, m_load, m_dir, m_lval, m_state);
                    end
                end
            end
            begin
                #1_000_000;
                bad++;
                $display("FAIL watchdog: run did not complete, got timeout expected finish");
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "watchdog");
            end
        join_none

        // Reset state
        rst = 1'b1;
        cyc(2);
        chk_on = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_led",  32'(state_led),    32'd0);
        check("rst_en",   32'(bus.cnt_en),   32'd0);
        check("rst_load", 32'(bus.cnt_load), 32'd0);
        check("rst_lval", 32'(bus.load_val), 32'd0);
        check("rst_dir",  32'(bus.cnt_dir),  32'd1);
        tick_auto = 1'b1;

        // Start latency: load on the third edge after the button is sampled
        dir_sw    = 1'b1;
        start_btn = 1'b1;
        @(negedge clk); check("start_lat_e1", 32'(bus.cnt_load), 32'd0);
        @(negedge clk); check("start_lat_e2", 32'(bus.cnt_load), 32'd0);
        @(negedge clk); check("start_lat_e3", 32'(bus.cnt_load), 32'd1);
        check("start_lval", 32'(bus.load_val), 32'd0);
        check("start_led",  32'(state_led),    32'd1);
        @(negedge clk); check("start_lat_e4", 32'(bus.cnt_load), 32'd0);
        start_btn = 1'b0;

        observe(40, ens, lds);
        check("run_steps_40cyc", 32'(ens), 32'd4);
        check("run_dir_up",      32'(bus.cnt_dir), 32'd1);

        // Upper limit without bounce -> DONE, then restart
        bounce_sw = 1'b0;
        wait_en();
        force_count(4'd15);
        observe(12, ens, lds);
        check("limit_no_step", 32'(ens), 32'd0);
        check("limit_done",    32'(state_led), 32'd3);
        press(1'b0, lds);
        check("done_reload", 32'(lds), 32'd1);
        check("done_to_run", 32'(state_led), 32'd1);
        check("done_lval",   32'(bus.load_val), 32'd0);

        bounce_sw = 1'b1;
        wait_en();
        force_count(4'd15);
`ifdef BOUNCE_MODE_EN
        found = 1'b0;
        en_at = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            @(negedge clk);
            if (!bus.cnt_dir) begin
                found = 1'b1;
                en_at = bus.cnt_en;
            end
        end
        check("bounce_top_dir", 32'(found), 32'd1);
        check("bounce_top_en",  32'(en_at), 32'd1);
        force_count(4'd0);
        found = 1'b0;
        for (int i = 0; i < 15 && !found; i++) begin
            @(negedge clk);
            if (bus.cnt_dir) found = 1'b1;
        end
        check("bounce_bot_dir", 32'(found), 32'd1);
        check("bounce_running", 32'(state_led), 32'd1);
`else
        observe(12, ens, lds);
        check("nobounce_no_step", 32'(ens), 32'd0);
        check("nobounce_done",    32'(state_led), 32'd3);
        press(1'b0, lds);
`endif
        bounce_sw = 1'b0;

        // Pause / resume / stop twice
        press(1'b1, lds);
        check("pause_led", 32'(state_led), 32'd2);
        observe(30, ens, lds);
        check("pause_no_step", 32'(ens), 32'd0);
        press(1'b0, lds);
        check("resume_no_load", 32'(lds), 32'd0);
        check("resume_led",     32'(state_led), 32'd1);
        press(1'b1, lds);
        press(1'b1, lds);
        check("stop_twice_idle", 32'(state_led), 32'd0);

        // Start and stop together while running
        press(1'b0, lds);
        @(negedge clk);
        start_btn = 1'b1;
        stop_btn  = 1'b1;
        cyc(3);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        cyc(3);
        check("both_btn_pause", 32'(state_led), 32'd2);

        // Tick coincident with the stop event
        press(1'b0, lds);
        tick_auto = 1'b0;
        cyc(2);
        stop_btn = 1'b1;
        cyc(2);
        man_tick = 1'b1;
        @(negedge clk);
        man_tick = 1'b0;
        observe(4, ens, lds);
        stop_btn = 1'b0;
        check("stop_tick_no_step", 32'(ens), 32'd0);
        check("stop_tick_pause",   32'(state_led), 32'd2);

        // Reset mid-run with a tick pending
        press(1'b1, lds);
        dir_sw = 1'b0;
        press(1'b0, lds);
        check("down_lval", 32'(bus.load_val), 32'd15);
        check("down_dir",  32'(bus.cnt_dir),  32'd0);
        man_tick = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        man_tick = 1'b0;
        rst      = 1'b0;
        check("midrst_led",  32'(state_led),    32'd0);
        check("midrst_en",   32'(bus.cnt_en),   32'd0);
        check("midrst_dir",  32'(bus.cnt_dir),  32'd1);
        check("midrst_lval", 32'(bus.load_val), 32'd0);
        observe(3, ens, lds);
        check("midrst_no_step", 32'(ens), 32'd0);
        tick_auto = 1'b1;
        dir_sw    = 1'b1;

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 24) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 39) == 0) stop_btn  = ~stop_btn;
            if ($urandom_range(0, 49) == 0) dir_sw    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 49) == 0) bounce_sw = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 799) == 0);
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 2))
                    0:       force_count(4'(MINV));
                    1:       force_count(4'(MAXV));
                    default: force_count(4'($urandom_range(0, 15)));
                endcase
            end
        end
        rst = 1'b0;
        cyc(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
